// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter and sequencer for the single-port data memory.
// Latency: accept at edge T -> mem_en in cycle T+1+LAT -> resp_valid from cycle T+2+LAT.
// Backpressure: one transaction in flight; req_ready stays low until the response handshakes.
module mem_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch unit, read-only
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  // load/store unit
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  // memory port (combinational read data)
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, RESP} state_t;

  localparam logic       OWN_IFU = 1'b0;
  localparam logic       OWN_LSU = 1'b1;
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        last_grant;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wr_q;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        accept;
  logic        resp_taken;

  // Round-robin grant, offered only in IDLE and never while reset is asserted
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && !rst) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = (last_grant == OWN_LSU);
        grant_lsu = (last_grant == OWN_IFU);
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  // A grant implies the matching valid, so a grant is an accept
  assign accept        = grant_ifu | grant_lsu;
  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign resp_taken    = (owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the per-state strobes (memory enable, response valids)
  always_comb begin
    state_nxt      = state;
    mem_en         = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (LAT_CNT != 4'd0) ? WAIT : ACC;
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = ACC;
      end
      ACC: begin
        mem_en    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        ifu_resp_valid = (owner == OWN_IFU);
        lsu_resp_valid = (owner == OWN_LSU);
        if (resp_taken) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_LSU;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_q       <= 1'b0;
      cnt        <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        owner      <= grant_lsu;
        last_grant <= grant_lsu;
        addr_q     <= grant_lsu ? lsu_addr : ifu_addr;
        wdata_q    <= grant_lsu ? lsu_wdata : 32'd0;
        wstrb_q    <= grant_lsu ? lsu_wstrb : 4'd0;
        wr_q       <= grant_lsu & lsu_wr;
        cnt        <= LAT_CNT;
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      // Captured once, in the single access cycle; writes return it too
      if (state == ACC) rdata_q <= mem_rdata;
    end
  end

  // mem_wr is qualified by the access cycle so it never shows outside ACC
  assign mem_wr    = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign ifu_rdata = rdata_q;
  assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT = 0, 3, 5) share one stimulus set.
// Each scenario starts from reset and checks only the instance it targets.
module tb_mem_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        ifu_resp_ready;
  logic        lsu_req_valid;
  logic        lsu_wr;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_resp_ready;
  logic [31:0] mem_rdata;

  logic [N-1:0] ifu_req_ready;
  logic [N-1:0] ifu_resp_valid;
  logic [N-1:0] lsu_req_ready;
  logic [N-1:0] lsu_resp_valid;
  logic [N-1:0] mem_en;
  logic [N-1:0] mem_wr;
  logic [31:0]  ifu_rdata [N];
  logic [31:0]  lsu_rdata [N];
  logic [31:0]  mem_addr  [N];
  logic [31:0]  mem_wdata [N];
  logic [3:0]   mem_wstrb [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(.LAT(g == 0 ? 0 : (g == 1 ? 3 : 5))) u_dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready[g]),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid[g]),
      .ifu_resp_ready (ifu_resp_ready),
      .ifu_rdata      (ifu_rdata[g]),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready[g]),
      .lsu_wr         (lsu_wr),
      .lsu_addr       (lsu_addr),
      .lsu_wdata      (lsu_wdata),
      .lsu_wstrb      (lsu_wstrb),
      .lsu_resp_valid (lsu_resp_valid[g]),
      .lsu_resp_ready (lsu_resp_ready),
      .lsu_rdata      (lsu_rdata[g]),
      .mem_en         (mem_en[g]),
      .mem_wr         (mem_wr[g]),
      .mem_addr       (mem_addr[g]),
      .mem_wdata      (mem_wdata[g]),
      .mem_wstrb      (mem_wstrb[g]),
      .mem_rdata      (mem_rdata)
    );

    // Running count of memory-enable and write cycles seen at each edge
    int en_cnt = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
      if (mem_en[g]) en_cnt <= en_cnt + 1;
      if (mem_wr[g]) wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic int en_count(input int k);
    case (k)
      0:       return g_dut[0].en_cnt;
      1:       return g_dut[1].en_cnt;
      default: return g_dut[2].en_cnt;
    endcase
  endfunction

  function automatic int wr_count(input int k);
    case (k)
      0:       return g_dut[0].wr_cnt;
      1:       return g_dut[1].wr_cnt;
      default: return g_dut[2].wr_cnt;
    endcase
  endfunction

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_wr         = 1'b0;
    lsu_addr       = '0;
    lsu_wdata      = '0;
    lsu_wstrb      = '0;
    lsu_resp_ready = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Every output of instance k at its reset value
  task automatic chk_reset_vals(input string tag, input int k);
    chk({tag, "_ifu_req_ready"},  ifu_req_ready[k],  0);
    chk({tag, "_lsu_req_ready"},  lsu_req_ready[k],  0);
    chk({tag, "_ifu_resp_valid"}, ifu_resp_valid[k], 0);
    chk({tag, "_lsu_resp_valid"}, lsu_resp_valid[k], 0);
    chk({tag, "_mem_en"},         mem_en[k],         0);
    chk({tag, "_mem_wr"},         mem_wr[k],         0);
    chk({tag, "_ifu_rdata"},      ifu_rdata[k],      0);
    chk({tag, "_lsu_rdata"},      lsu_rdata[k],      0);
    chk({tag, "_mem_addr"},       mem_addr[k],       0);
    chk({tag, "_mem_wdata"},      mem_wdata[k],      0);
    chk({tag, "_mem_wstrb"},      {28'd0, mem_wstrb[k]}, 0);
  endtask

  // Grant vectors applied in IDLE straight after reset (last grant = LSU)
  typedef struct {
    logic rst;
    logic ifu_v;
    logic lsu_v;
    logic exp_ifu_rdy;
    logic exp_lsu_rdy;
  } gvec_t;

  gvec_t gv [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    int e0;
    int w0;
    int waited;
    int e_idle [N];
    logic bad;

    gv[0] = '{rst: 1'b0, ifu_v: 1'b0, lsu_v: 1'b0, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};
    gv[1] = '{rst: 1'b0, ifu_v: 1'b1, lsu_v: 1'b0, exp_ifu_rdy: 1'b1, exp_lsu_rdy: 1'b0};
    gv[2] = '{rst: 1'b0, ifu_v: 1'b0, lsu_v: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b1};
    gv[3] = '{rst: 1'b0, ifu_v: 1'b1, lsu_v: 1'b1, exp_ifu_rdy: 1'b1, exp_lsu_rdy: 1'b0};
    gv[4] = '{rst: 1'b1, ifu_v: 1'b1, lsu_v: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};

    // Reset state, with both valids high to show reset masks the grant
    clear_inputs();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    step();
    step();
    for (int k = 0; k < N; k++) chk_reset_vals($sformatf("reset_i%0d", k), k);
    do_reset();

    // Combinational grant table; valids drop before the edge so nothing is accepted
    for (int i = 0; i < 5; i++) begin
      step();
      rst           = gv[i].rst;
      ifu_req_valid = gv[i].ifu_v;
      lsu_req_valid = gv[i].lsu_v;
      #1;
      for (int k = 0; k < N; k++) begin
        chk($sformatf("grant%0d_ifu_rdy_i%0d", i, k), ifu_req_ready[k], gv[i].exp_ifu_rdy);
        chk($sformatf("grant%0d_lsu_rdy_i%0d", i, k), lsu_req_ready[k], gv[i].exp_lsu_rdy);
      end
      #1;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      rst           = 1'b0;
    end

    // IFU read, LAT=0 (instance 0)
    do_reset();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    mem_rdata     = 32'hDEAD_BEEF;
    #1;
    chk("ifu_rd_req_ready", ifu_req_ready[0], 1);
    e0 = en_count(0);
    step();
    ifu_req_valid = 1'b0;
    chk("ifu_rd_mem_en",      mem_en[0],         1);
    chk("ifu_rd_mem_wr",      mem_wr[0],         0);
    chk("ifu_rd_mem_addr",    mem_addr[0],       32'h8000_0000);
    chk("ifu_rd_early_resp",  ifu_resp_valid[0], 0);
    step();
    chk("ifu_rd_mem_en_off",  mem_en[0],         0);
    chk("ifu_rd_resp_valid",  ifu_resp_valid[0], 1);
    chk("ifu_rd_rdata",       ifu_rdata[0],      32'hDEAD_BEEF);
    chk("ifu_rd_lsu_resp",    lsu_resp_valid[0], 0);
    ifu_resp_ready = 1'b1;
    step();
    chk("ifu_rd_resp_done",   ifu_resp_valid[0], 0);
    chk("ifu_rd_en_cycles",   en_count(0) - e0,  1);

    // LSU write, LAT=3 (instance 1), then 5 cycles of response backpressure
    do_reset();
    lsu_req_valid = 1'b1;
    lsu_wr        = 1'b1;
    lsu_addr      = 32'h8000_0010;
    lsu_wdata     = 32'h1234_5678;
    lsu_wstrb     = 4'b0011;
    mem_rdata     = 32'hCAFE_F00D;
    #1;
    chk("lsu_wr_req_ready", lsu_req_ready[1], 1);
    e0 = en_count(1);
    w0 = wr_count(1);
    step();
    lsu_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("lsu_wr_wait%0d_mem_en", c), mem_en[1], 0);
      step();
    end
    chk("lsu_wr_mem_en",    mem_en[1],    1);
    chk("lsu_wr_mem_wr",    mem_wr[1],    1);
    chk("lsu_wr_mem_addr",  mem_addr[1],  32'h8000_0010);
    chk("lsu_wr_mem_wdata", mem_wdata[1], 32'h1234_5678);
    chk("lsu_wr_mem_wstrb", {28'd0, mem_wstrb[1]}, 32'h3);
    step();
    chk("lsu_wr_resp_valid", lsu_resp_valid[1], 1);
    chk("lsu_wr_rdata",      lsu_rdata[1],      32'hCAFE_F00D);
    chk("lsu_wr_ifu_resp",   ifu_resp_valid[1], 0);
    // New memory data and a pending IFU request must not disturb the held response
    mem_rdata     = 32'h1111_1111;
    ifu_req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_resp_valid", c), lsu_resp_valid[1], 1);
      chk($sformatf("bp%0d_rdata", c),      lsu_rdata[1],      32'hCAFE_F00D);
      chk($sformatf("bp%0d_ifu_rdy", c),    ifu_req_ready[1],  0);
      chk($sformatf("bp%0d_lsu_rdy", c),    lsu_req_ready[1],  0);
      chk($sformatf("bp%0d_mem_en", c),     mem_en[1],         0);
      step();
    end
    ifu_req_valid  = 1'b0;
    lsu_resp_ready = 1'b1;
    step();
    chk("lsu_wr_resp_done", lsu_resp_valid[1],  0);
    chk("lsu_wr_en_cycles", en_count(1) - e0,   1);
    chk("lsu_wr_wr_cycles", wr_count(1) - w0,   1);

    // Simultaneous requests from reset alternate IFU, LSU, IFU, LSU (instance 0)
    do_reset();
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0100;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_0200;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      while (!(ifu_req_ready[0] || lsu_req_ready[0]) && waited < 8) begin
        step();
        waited++;
      end
      chk($sformatf("rr%0d_ifu_rdy", t), ifu_req_ready[0], (t % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_lsu_rdy", t), lsu_req_ready[0], (t % 2 == 1) ? 1 : 0);
      if (t > 0) chk($sformatf("rr%0d_gap", t), waited, 2);
      step();
    end

    // Reset during WAIT, LAT=5 (instance 2)
    do_reset();
    lsu_req_valid = 1'b1;
    lsu_wr        = 1'b1;
    lsu_addr      = 32'h8000_0020;
    lsu_wdata     = 32'hA5A5_A5A5;
    lsu_wstrb     = 4'b1111;
    lsu_resp_ready = 1'b1;
    #1;
    chk("rstw_req_ready", lsu_req_ready[2], 1);
    e0 = en_count(2);
    step();
    lsu_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("rstw_after", 2);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (lsu_resp_valid[2] || ifu_resp_valid[2]) bad = 1'b1;
    end
    chk("rstw_no_resp",      bad,               0);
    chk("rstw_no_mem_en",    en_count(2) - e0,  0);

    // Idle: no valids for 10 cycles, no memory access anywhere
    do_reset();
    for (int k = 0; k < N; k++) e_idle[k] = en_count(k);
    repeat (10) step();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("idle_mem_en_i%0d", k), en_count(k) - e_idle[k], 0);
      chk($sformatf("idle_ifu_rdy_i%0d", k), ifu_req_ready[k], 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the NPC single-port data memory. Accepts requests from the instruction fetch unit (read-only) and the load/store unit (read/write), grants one at a time with round-robin priority, and drives the combinational memory port for exactly one cycle per transaction. An optional programmable wait emulates memory latency. The captured read data is returned through a valid/ready response channel.

## Interface
- `LAT`, default 1: extra wait cycles before the memory access, 0..15.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `ifu_req_valid` in 1: IFU read request.
- `ifu_req_ready` out 1: IFU request accepted this cycle.
- `ifu_addr` in 32: IFU read address.
- `ifu_resp_valid` out 1: IFU read data available.
- `ifu_resp_ready` in 1: IFU takes the response.
- `ifu_rdata` out 32: IFU read data.
- `lsu_req_valid` in 1: LSU request.
- `lsu_req_ready` out 1: LSU request accepted this cycle.
- `lsu_wr` in 1: 1 = write, 0 = read.
- `lsu_addr` in 32, `lsu_wdata` in 32, `lsu_wstrb` in 4: LSU address, write data and byte strobes.
- `lsu_resp_valid` out 1: LSU response available.
- `lsu_resp_ready` in 1: LSU takes the response.
- `lsu_rdata` out 32: LSU response data.
- `mem_en` out 1, `mem_wr` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: drive the memory port.
- `mem_rdata` in 32: combinational data returned by the memory.

## Operation
- **FSM states:** IDLE, WAIT, ACC, RESP. Reset puts the FSM in IDLE.
- **Grant (IDLE only):**
  - Only one `*_req_valid` high: that requester is granted.
  - Both high: the requester not granted last time is granted.
  - `last_grant` resets to LSU, so the first tie goes to IFU.
  - The granted `*_req_ready` is high combinationally in IDLE; the other is 0. Both are 0 outside IDLE and while `rst` is high.
- **Accept:** on a cycle with `valid && ready`:
  - Latch owner, addr, wr, wdata and wstrb. For IFU, wr=0 and wstrb=0.
  - Update `last_grant`.
  - Load the 4-bit counter with `LAT`.
  - Go to WAIT if `LAT` > 0, else ACC.
- **WAIT:** decrement the counter each cycle. Leave for ACC on the cycle the counter reads 1.
- **ACC:**
  - `mem_en`=1 for exactly one cycle. `mem_wr` equals the latched wr.
  - Register `mem_rdata` into the response register. Write responses also carry `mem_rdata`.
  - Go to RESP.
- **RESP:**
  - The owner's `*_resp_valid` is 1; the other port's is 0.
  - Data is held stable until `*_resp_ready`.
  - On handshake, go to IDLE. A new request can be accepted the next cycle.
- **Memory port:**
  - `mem_en` and `mem_wr` are 0 outside ACC.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` always show the latched values.
  - There is never more than one `mem_en` cycle per transaction, so write side effects happen exactly once.
- **Reset mid-transaction:** the FSM returns to IDLE and the pending transaction is dropped. No memory access and no response occur, even if reset hits in WAIT. If reset is asserted in ACC, that access has already happened and nothing more follows.
- Requests are not queued. A requester holds `valid` and its payload until it sees ready.

## Timing
- **Reset values:** `ifu_req_ready`, `lsu_req_ready`, `ifu_resp_valid`, `lsu_resp_valid`, `mem_en` and `mem_wr` are 0. `ifu_rdata`, `lsu_rdata`, `mem_addr`, `mem_wdata` and `mem_wstrb` are 0. `last_grant` is LSU.
- **Latency:** accept at edge T gives `mem_en` in cycle T+1+LAT and `resp_valid` from cycle T+2+LAT.
- **Back-to-back throughput:** one transaction per 3+LAT cycles when responses are taken immediately.
- Response data is valid in the same cycle as `resp_valid` and is registered, with no combinational path from `mem_rdata`.
- `ifu_rdata` and `lsu_rdata` both come from the shared response register. Only the owner's `resp_valid` qualifies it.

## Test plan
- **IFU read, LAT=0:** the IFU requests a read at 0x8000_0000, and memory returns 0xDEADBEEF. Required: `mem_en` for one cycle with `mem_wr`=0; `ifu_resp_valid` 2 cycles after accept with `ifu_rdata`=0xDEADBEEF; `lsu_resp_valid` stays 0.
- **LSU write, LAT=3:** the LSU writes addr 0x8000_0010, wdata 0x1234_5678, wstrb 0b0011. Required: exactly one `mem_en`/`mem_wr` cycle, 4 cycles after accept, with matching addr, data and strobe; then `lsu_resp_valid`.
- **Simultaneous requests from reset:** both request together. Required: IFU is granted first, then LSU, then IFU, then LSU, alternating while both hold valid.
- **Response backpressure:** hold `lsu_resp_ready`=0 for 5 cycles. Required: `lsu_resp_valid` and `lsu_rdata` stay stable, both `req_ready` stay 0, and `mem_en` stays 0.
- **Reset during WAIT:** with LAT=5, assert `rst` for one cycle two cycles after accepting a write. Required: no `mem_en` cycle occurs, no response occurs, and all outputs are at their reset values on the following cycle.
- **Idle:** keep all valids low for 10 cycles. Required: `mem_en` is never asserted.
